// File: rtl/frame_rate_meter_pkg.sv
// Shared constants, FSM encodings and the saturating-increment helper for frame_rate_meter.
package frame_rate_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int CNT_MAX   = 2**CNT_W_DEF - 1;

  localparam logic [0:0] ST_FIRST = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  // Returns max_v unchanged once reached, so callers never wrap.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/frame_rate_meter_window_timer.sv
// Free-running window timer: tick_out marks the last cycle of every WINDOW_CYCLES-long window.
// Latency: tick_out is combinational from the counter; no backpressure (always runs).
module window_timer #(
  parameter int WINDOW_CYCLES = 50_000_000
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic tick_out
);

  localparam int                WCNT_W = $clog2(WINDOW_CYCLES);
  localparam logic [WCNT_W-1:0] LAST   = WCNT_W'(WINDOW_CYCLES - 1);

  logic [WCNT_W-1:0] wcnt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wcnt <= '0;
    end else if (wcnt == LAST) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + WCNT_W'(1);
    end
  end

  assign tick_out = (wcnt == LAST);

endmodule

// File: rtl/frame_rate_meter.sv
// Counts rising edges of frame_done_in per window and publishes a saturated total with a strobe.
// Latency: outputs update on the edge ending each window; no backpressure. Optional: FRAME_RATE_PEAK_EN.
// FRAME_RATE_PEAK_EN builds a running-maximum register behind peak_out; otherwise peak_out is 0.
module frame_rate_meter
  import frame_rate_pkg::*;
#(
  parameter int WINDOW_CYCLES = 50_000_000,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             frame_done_in,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid_out,
  output logic             overflow_out,
  output logic [CNT_W-1:0] peak_out
);

  localparam logic [CNT_W-1:0] SAT_MAX = '1;

  logic             tick;
  logic             frame_d;
  logic             rise;
  logic [CNT_W-1:0] ecnt;
  logic [CNT_W-1:0] ecnt_inc;
  logic [CNT_W-1:0] close_val;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             valid_q;
  logic [0:0]       state;

  window_timer #(
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) u_timer (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .tick_out(tick)
  );

  assign rise     = frame_done_in & ~frame_d;
  assign ecnt_inc = CNT_W'(sat_inc(32'(ecnt), 32'(SAT_MAX)));
  // A rise in the closing cycle still belongs to the window that is closing.
  assign close_val = rise ? ecnt_inc : ecnt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame_d    <= 1'b0;
      ecnt       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      state      <= ST_FIRST;
    end else begin
      frame_d <= frame_done_in;
      valid_q <= 1'b0;
      if (tick) begin
        count_q    <= close_val;
        overflow_q <= (close_val == SAT_MAX);
        valid_q    <= 1'b1;
        ecnt       <= '0;
        state      <= ST_RUN;
      end else if (rise) begin
        ecnt <= ecnt_inc;
      end
    end
  end

  // Nothing is published until the first window after reset has closed.
  assign count_out       = (state == ST_RUN) ? count_q : '0;
  assign overflow_out    = (state == ST_RUN) & overflow_q;
  assign count_valid_out = valid_q;

`ifdef FRAME_RATE_PEAK_EN
  logic [CNT_W-1:0] peak_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      peak_q <= '0;
    end else if (tick && (close_val > peak_q)) begin
      peak_q <= close_val;
    end
  end

  assign peak_out = peak_q;
`else
  assign peak_out = '0;
`endif

endmodule
